// File: rtl/pipelined_addsub.sv
// Streaming add/subtract unit whose carry chain is cut into STAGES registered segments.
// Define PIPELINED_ADDSUB_OVF_EN to generate the signed-overflow output; otherwise out_ovf is tied to 0.
module pipelined_addsub #(
   parameter int WIDTH  = 24,
   parameter int STAGES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

   logic             w_en;
   logic [WIDTH-1:0] w_bx;

   assign w_en     = !out_valid || out_ready;
   assign in_ready = w_en;
   assign w_bx     = in_sub ? ~in_b : in_b;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      // A rounded-up SEG can leave trailing stages with no bits; they only delay.
      localparam int LO = (k * SEG < WIDTH) ? k * SEG : WIDTH;
      localparam int HI = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG : WIDTH;
      localparam int N  = HI - LO;

      logic          w_c_in, w_c_nx, w_v_in;
      logic          r_c, r_v;
      logic [HI-1:0] w_s_nx, r_s;
`ifdef PIPELINED_ADDSUB_OVF_EN
      logic          w_o_in, w_o_nx, r_o;
`endif

      if (k == 0) begin : g_first
         assign w_c_in = in_sub | in_cin;
         assign w_v_in = in_valid;
`ifdef PIPELINED_ADDSUB_OVF_EN
         assign w_o_in = 1'b0;
`endif
      end else begin : g_next
         assign w_c_in = g_st[k-1].r_c;
         assign w_v_in = g_st[k-1].r_v;
`ifdef PIPELINED_ADDSUB_OVF_EN
         assign w_o_in = g_st[k-1].r_o;
`endif
      end

      if (N > 0) begin : g_add
         logic [N-1:0] w_sa, w_sb;
         logic [N:0]   w_part;
         if (k == 0) begin : g_src
            assign w_sa   = in_a[N-1:0];
            assign w_sb   = w_bx[N-1:0];
            assign w_s_nx = w_part[N-1:0];
         end else begin : g_src
            assign w_sa   = g_st[k-1].g_up.r_a[LO +: N];
            assign w_sb   = g_st[k-1].g_up.r_b[LO +: N];
            assign w_s_nx = {w_part[N-1:0], g_st[k-1].r_s};
         end
         assign w_part = {1'b0, w_sa} + {1'b0, w_sb} + {{N{1'b0}}, w_c_in};
         assign w_c_nx = w_part[N];
`ifdef PIPELINED_ADDSUB_OVF_EN
         if (HI == WIDTH) begin : g_ovf
            // carry into the MSB recovered as a ^ b ^ sum at that bit
            assign w_o_nx = w_part[N] ^ w_sa[N-1] ^ w_sb[N-1] ^ w_part[N-1];
         end else begin : g_ovf_pass
            assign w_o_nx = w_o_in;
         end
`endif
      end else begin : g_pass
         assign w_s_nx = g_st[k-1].r_s;
         assign w_c_nx = w_c_in;
`ifdef PIPELINED_ADDSUB_OVF_EN
         assign w_o_nx = w_o_in;
`endif
      end

      if (HI < WIDTH) begin : g_up
         logic [WIDTH-1:HI] w_a_nx, w_b_nx, r_a, r_b;
         if (k == 0) begin : g_src
            assign w_a_nx = in_a[WIDTH-1:HI];
            assign w_b_nx = w_bx[WIDTH-1:HI];
         end else begin : g_src
            assign w_a_nx = g_st[k-1].g_up.r_a[WIDTH-1:HI];
            assign w_b_nx = g_st[k-1].g_up.r_b[WIDTH-1:HI];
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_en) begin
               r_a <= w_a_nx;
               r_b <= w_b_nx;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_v <= 1'b0;
            r_c <= 1'b0;
            r_s <= '0;
         end else if (w_en) begin
            r_v <= w_v_in;
            r_c <= w_c_nx;
            r_s <= w_s_nx;
         end
      end

`ifdef PIPELINED_ADDSUB_OVF_EN
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)    r_o <= 1'b0;
         else if (w_en) r_o <= w_o_nx;
      end
`endif
   end

   assign out_valid = g_st[STAGES-1].r_v;
   assign out_sum   = g_st[STAGES-1].r_s;
   assign out_cout  = g_st[STAGES-1].r_c;
`ifdef PIPELINED_ADDSUB_OVF_EN
   assign out_ovf   = g_st[STAGES-1].r_o;
`else
   assign out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: default 24/3 instance plus 32/4, 8/1 and 8/8 instances.
module tb_pipelined_addsub;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_cin, in_sub;
   logic [23:0] in_a, in_b, out_sum;
   logic        out_valid, out_ready, out_cout, out_ovf;

   logic        x_valid, x_cin, x_sub;
   logic [31:0] x_a, x_b;
   logic        r32_rdy, r32_v, r32_c, r32_o;
   logic [31:0] r32_s;
   logic        r1_rdy, r1_v, r1_c, r1_o;
   logic [7:0]  r1_s;
   logic        rw_rdy, rw_v, rw_c, rw_o;
   logic [7:0]  rw_s;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipelined_addsub #(.WIDTH(24), .STAGES(3)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_cout(out_cout), .out_ovf(out_ovf));

   pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(r32_rdy),
      .in_a(x_a), .in_b(x_b), .in_cin(x_cin), .in_sub(x_sub),
      .out_valid(r32_v), .out_ready(1'b1), .out_sum(r32_s),
      .out_cout(r32_c), .out_ovf(r32_o));

   pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(r1_rdy),
      .in_a(x_a[7:0]), .in_b(x_b[7:0]), .in_cin(x_cin), .in_sub(x_sub),
      .out_valid(r1_v), .out_ready(1'b1), .out_sum(r1_s),
      .out_cout(r1_c), .out_ovf(r1_o));

   pipelined_addsub #(.WIDTH(8), .STAGES(8)) dutw (
      .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(rw_rdy),
      .in_a(x_a[7:0]), .in_b(x_b[7:0]), .in_cin(x_cin), .in_sub(x_sub),
      .out_valid(rw_v), .out_ready(1'b1), .out_sum(rw_s),
      .out_cout(rw_c), .out_ovf(rw_o));

   // Reference result packed as {ovf, cout, sum[31:0]} for a w-bit unit.
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub, input int w);
      logic [32:0] m, bx, full;
      logic        ovf;
      m    = (33'd1 << w) - 33'd1;
      bx   = {1'b0, (sub ? ~b : b)} & m;
      full = ({1'b0, a} & m) + bx + {32'd0, (sub | cin)};
      ovf  = 1'b0;
`ifdef PIPELINED_ADDSUB_OVF_EN
      ovf  = (a[w-1] == bx[w-1]) && (full[w-1] != a[w-1]);
`endif
      return {ovf, full[w], full[31:0] & m[31:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic one_shot(input logic [23:0] a, input logic [23:0] b,
                           input logic cin, input logic sub, input string tag);
      logic [33:0] e;
      e = model({8'd0, a}, {8'd0, b}, cin, sub, 24);
      @(negedge clk);
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 1; c < 3; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         chk({tag, "_early"}, 64'(out_valid), 64'd0);
      end
      @(negedge clk);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_sum"},   64'(out_sum),   64'(e[23:0]));
      chk({tag, "_cout"},  64'(out_cout),  64'(e[32]));
      chk({tag, "_ovf"},   64'(out_ovf),   64'(e[33]));
   endtask

   initial begin
      logic [23:0] va [10];
      logic [23:0] vb [10];
      logic        vs [10];
      logic        vc [10];
      logic [33:0] q [$];
      logic [33:0] e, snap;
      logic        stall;
      int          sent, recv;

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      out_ready = 1'b1; x_valid = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_sum",   64'(out_sum),   64'd0);
      chk("rst_cout",  64'(out_cout),  64'd0);
      chk("rst_ovf",   64'(out_ovf),   64'd0);
      chk("rst_ready", 64'(in_ready),  64'd1);
      rst_n = 1'b1;

      one_shot(24'hFFFFFF, 24'h000001, 1'b0, 1'b0, "wrap");
      one_shot(24'h000005, 24'h000007, 1'b0, 1'b1, "sub5m7");
      one_shot(24'h000007, 24'h000005, 1'b0, 1'b1, "sub7m5");
      one_shot(24'h0000FF, 24'h000000, 1'b1, 1'b0, "cin_seg");
      one_shot(24'h7FFFFF, 24'h000001, 1'b0, 1'b0, "ovf_pos");
      one_shot(24'h800000, 24'h000001, 1'b1, 1'b1, "ovf_neg");

      // Backpressure stream: out_ready follows 1,0,0,1 per cycle.
      for (int i = 0; i < 10; i++) begin
         va[i] = 24'($urandom); vb[i] = 24'($urandom);
         vs[i] = 1'($urandom); vc[i] = 1'($urandom);
      end
      sent = 0; recv = 0; stall = 1'b0; snap = '0;
      for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
         @(negedge clk);
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         if (stall) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_hold", 64'({out_ovf, out_cout, out_sum}), 64'({snap[33:32], snap[23:0]}));
         end
         stall = 1'b0;
         if (sent < 10) begin
            in_valid = 1'b1; in_a = va[sent]; in_b = vb[sent];
            in_sub = vs[sent]; in_cin = vc[sent];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         chk("bp_ready", 64'(in_ready), 64'(!out_valid || out_ready));
         if (out_valid) begin
            if (out_ready) begin
               e = (q.size() > 0) ? q.pop_front() : 34'h3_FFFF_FFFF;
               chk("bp_sum",  64'(out_sum),  64'(e[23:0]));
               chk("bp_cout", 64'(out_cout), 64'(e[32]));
               chk("bp_ovf",  64'(out_ovf),  64'(e[33]));
               recv++;
            end else begin
               stall = 1'b1;
               snap  = {out_ovf, out_cout, 8'd0, out_sum};
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model({8'd0, va[sent]}, {8'd0, vb[sent]}, vc[sent], vs[sent], 24));
            sent++;
         end
      end
      chk("bp_count", 64'(recv), 64'd10);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(negedge clk);

      // Reset with one result stalled at the output and two more in flight.
      out_ready = 1'b0;
      in_a = 24'd10; in_b = 24'd20; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
      @(negedge clk); in_a = 24'd11;
      @(negedge clk); in_a = 24'd12;
      @(negedge clk); in_valid = 1'b0;
      chk("mid_valid_pre", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_valid_rst", 64'(out_valid), 64'd0);
      chk("mid_sum_rst",   64'(out_sum),   64'd0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      one_shot(24'd3, 24'd4, 1'b0, 1'b0, "post_rst");

      // Other builds: one item at a time, latency and value checked per instance.
      for (int v = 0; v < 16; v++) begin
         logic [33:0] e32, e8;
         @(negedge clk);
         x_valid = 1'b1;
         if (v == 0)      begin x_a = 32'h00FFFFFF; x_b = 32'd1; x_sub = 1'b0; x_cin = 1'b0; end
         else if (v == 1) begin x_a = 32'h7FFFFFFF; x_b = 32'd1; x_sub = 1'b0; x_cin = 1'b0; end
         else begin
            x_a = $urandom; x_b = $urandom; x_sub = 1'($urandom); x_cin = 1'($urandom);
         end
         e32 = model(x_a, x_b, x_cin, x_sub, 32);
         e8  = model({24'd0, x_a[7:0]}, {24'd0, x_b[7:0]}, x_cin, x_sub, 8);
         for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            x_valid = 1'b0;
            chk("s1_valid",  64'(r1_v),  64'(c == 1));
            chk("s4_valid",  64'(r32_v), 64'(c == 4));
            chk("s8_valid",  64'(rw_v),  64'(c == 8));
            if (c == 1) chk("s1_res", 64'({r1_o, r1_c, r1_s}), 64'({e8[33:32], e8[7:0]}));
            if (c == 4) chk("s4_res", 64'({r32_o, r32_c, r32_s}), 64'(e32));
            if (c == 8) chk("s8_res", 64'({rw_o, rw_c, rw_s}), 64'({e8[33:32], e8[7:0]}));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
